// File: rtl/axi_wr_burst_sched_if.sv
// Burst command channel plus AXI write-response channel between the scheduler
// (master) and the write engine / interconnect (slave).
interface axi_wr_burst_sched_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  m_axi_bvalid;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bready;

    modport master (
        output cmd_valid, cmd_addr, m_axi_bready,
        input  cmd_ready, m_axi_bvalid, m_axi_bresp
    );

    modport slave (
        input  cmd_valid, cmd_addr, m_axi_bready,
        output cmd_ready, m_axi_bvalid, m_axi_bresp
    );
endinterface

// File: rtl/axi_wr_burst_sched.sv
// Frame-based scheduler of fixed-size write bursts into a DDR ring buffer.
// Optional macro WR_SCHED_ERR_STOP_EN: a non-OKAY bresp parks the FSM in HALT.
//
// state   | meaning
// IDLE    | waiting for start with a non-zero frame_len
// ISSUE   | offering burst commands, bounded by frame_len and MAX_OUTSTANDING
// DRAIN   | no new commands; waiting for remaining B responses
// DONE    | one-cycle frame_done pulse
// HALT    | error stop, left only by reset (macro build only)
module axi_wr_burst_sched #(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h2000_0000,
    parameter logic [ADDR_WIDTH-1:0] BUF_BYTES       = 32'h0100_0000,
    parameter int unsigned           BURST_BYTES     = 128,
    parameter int unsigned           MAX_OUTSTANDING = 4
) (
    input  logic                        m_axi_aclk,
    input  logic                        m_axi_areset,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic [15:0]                 i_frame_len,
    axi_wr_burst_sched_if.master        bus,
    output logic                        o_busy,
    output logic                        o_frame_done,
    output logic [3:0]                  o_outstanding,
    output logic                        o_err
);

`ifdef WR_SCHED_ERR_STOP_EN
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_HALT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
`endif

    localparam logic [ADDR_WIDTH:0] LP_BURST = (ADDR_WIDTH+1)'(BURST_BYTES);
    localparam logic [ADDR_WIDTH:0] LP_END   = {1'b0, BASE_ADDR} + {1'b0, BUF_BYTES};
    localparam logic [3:0]          LP_MAX   = 4'(MAX_OUTSTANDING);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [15:0]           r_len;
    logic [15:0]           r_issued;
    logic [3:0]            r_out;
    logic                  r_cmd_valid;
    logic                  r_bready;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_err;

    logic                  w_cmd_hs;
    logic                  w_b_hs;
    logic                  w_bad_resp;
    logic                  w_b_err;
    logic [ADDR_WIDTH:0]   w_ptr_inc;
    logic [ADDR_WIDTH-1:0] w_ptr_nx;
    logic [15:0]           w_issued_nx;
    logic [3:0]            w_out_nx;
    logic                  w_can_issue;

    assign w_cmd_hs    = r_cmd_valid & bus.cmd_ready;
    assign w_b_hs      = r_bready & bus.m_axi_bvalid;
    assign w_bad_resp  = w_b_hs & (bus.m_axi_bresp != 2'b00);
    assign w_b_err     = w_bad_resp | (w_b_hs & (r_out == 4'd0));
    assign w_ptr_inc   = {1'b0, r_ptr} + LP_BURST;
    assign w_ptr_nx    = !w_cmd_hs ? r_ptr :
                         (w_ptr_inc >= LP_END) ? BASE_ADDR : w_ptr_inc[ADDR_WIDTH-1:0];
    assign w_issued_nx = r_issued + {15'd0, w_cmd_hs};
    assign w_can_issue = (w_issued_nx < r_len) && (w_out_nx < LP_MAX);

    // A B beat with nothing outstanding is flagged as an error, never an underflow.
    always_comb begin
        w_out_nx = r_out;
        if (w_cmd_hs && !w_b_hs)
            w_out_nx = r_out + 4'd1;
        else if (!w_cmd_hs && w_b_hs && (r_out != 4'd0))
            w_out_nx = r_out - 4'd1;
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_state      <= S_IDLE;
            r_ptr        <= BASE_ADDR;
            r_len        <= 16'd0;
            r_issued     <= 16'd0;
            r_out        <= 4'd0;
            r_cmd_valid  <= 1'b0;
            r_bready     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_bready     <= 1'b1;
            r_ptr        <= w_ptr_nx;
            r_out        <= w_out_nx;
            r_issued     <= w_issued_nx;
            r_frame_done <= 1'b0;
            if (w_b_err)
                r_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_cmd_valid <= 1'b0;
                    if (i_start && (i_frame_len != 16'd0)) begin
                        r_state     <= S_ISSUE;
                        r_len       <= i_frame_len;
                        r_issued    <= 16'd0;
                        r_cmd_valid <= (w_out_nx < LP_MAX);
                        r_busy      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // An offered command must complete before abort takes effect.
                    if ((w_cmd_hs && (w_issued_nx == r_len)) ||
                        (i_abort && (!r_cmd_valid || w_cmd_hs))) begin
                        r_state     <= S_DRAIN;
                        r_cmd_valid <= 1'b0;
                    end else if (r_cmd_valid && !w_cmd_hs) begin
                        r_cmd_valid <= 1'b1;
                    end else begin
                        r_cmd_valid <= w_can_issue;
                    end
                end
                S_DRAIN: begin
                    r_cmd_valid <= 1'b0;
                    if (r_out == 4'd0) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_cmd_valid <= 1'b0;
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                end
`ifdef WR_SCHED_ERR_STOP_EN
                S_HALT: begin
                    r_cmd_valid <= 1'b0;
                    r_busy      <= 1'b1;
                end
`endif
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase

`ifdef WR_SCHED_ERR_STOP_EN
            if (w_bad_resp && ((r_state == S_ISSUE) || (r_state == S_DRAIN) ||
                               (r_state == S_DONE))) begin
                r_state      <= S_HALT;
                r_cmd_valid  <= 1'b0;
                r_busy       <= 1'b1;
                r_frame_done <= 1'b0;
            end
`endif
        end
    end

    assign bus.cmd_valid    = r_cmd_valid;
    assign bus.cmd_addr     = r_ptr;
    assign bus.m_axi_bready = r_bready;
    assign o_busy           = r_busy;
    assign o_frame_done     = r_frame_done;
    assign o_outstanding    = r_out;
    assign o_err            = r_err;

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Bench for axi_wr_burst_sched: cycle table, directed corner sequences and
// randomized frames checked against a counting/ring-index reference model.
module tb_axi_wr_burst_sched;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam logic [31:0] BUF   = 32'h0000_0400;   // small ring so wrap is reachable quickly
    localparam int          BURST = 128;
    localparam int          RING  = 8;
    localparam int          MAXO  = 4;

    logic        m_axi_aclk = 1'b0;
    logic        m_axi_areset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [15:0] i_frame_len = 16'd0;
    logic        o_busy, o_frame_done, o_err;
    logic [3:0]  o_outstanding;

    axi_wr_burst_sched_if #(.ADDR_WIDTH(32)) bus ();

    axi_wr_burst_sched #(
        .ADDR_WIDTH(32), .BASE_ADDR(BASE), .BUF_BYTES(BUF),
        .BURST_BYTES(BURST), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .m_axi_aclk(m_axi_aclk), .m_axi_areset(m_axi_areset),
        .i_start(i_start), .i_abort(i_abort), .i_frame_len(i_frame_len),
        .bus(bus),
        .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_outstanding(o_outstanding), .o_err(o_err)
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    typedef struct {
        bit          st;
        logic [15:0] len;
        bit          rdy;
        bit          bv;
        bit          e_v;
        logic [31:0] e_a;
        bit          e_bz;
        bit          e_fd;
        logic [3:0]  e_o;
        bit          e_e;
    } vec_t;

    vec_t        tbl[15];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0;
    int          model_idx, model_out, last_due;
    int          q_b[$];
    logic [31:0] q_addr[$];
    int          hs_cnt, fd_cnt, b_cnt;
    bit          exp_err, hold_pend;
    logic [31:0] hold_addr;
    int          b_dmin = 1, b_dmax = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        m_axi_areset = 1'b1;
        i_start = 1'b0; i_abort = 1'b0; i_frame_len = 16'd0;
        bus.cmd_ready = 1'b0; bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
        @(posedge m_axi_aclk); #1;
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_cmd_addr", bus.cmd_addr, BASE);
        chk("rst_bready", 32'(bus.m_axi_bready), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_frame_done", 32'(o_frame_done), 32'd0);
        chk("rst_outstanding", 32'(o_outstanding), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        m_axi_areset = 1'b0;
        model_idx = 0; model_out = 0; last_due = 0;
        q_b.delete(); q_addr.delete();
        exp_err = 1'b0; hold_pend = 1'b0;
        hs_cnt = 0; fd_cnt = 0; b_cnt = 0;
        @(posedge m_axi_aclk); #1;
        chk("bready_after_reset", 32'(bus.m_axi_bready), 32'd1);
    endtask

    // One clock of the write-engine model: decide handshakes, predict, advance, check.
    task automatic cycle(input bit rdy, input bit allow_b, input bit bad);
        bit          c_hs, b_hs;
        int          due;
        logic [31:0] exp_addr;
        bus.cmd_ready    = rdy;
        b_hs             = allow_b && (q_b.size() > 0) && (q_b[0] <= cyc);
        bus.m_axi_bvalid = b_hs;
        bus.m_axi_bresp  = bad ? 2'b10 : 2'b00;
        c_hs             = bus.cmd_valid && rdy;
        if (hold_pend) begin
            chk("hold_valid", 32'(bus.cmd_valid), 32'd1);
            chk("hold_addr", bus.cmd_addr, hold_addr);
        end
        if (c_hs) begin
            exp_addr = BASE + 32'((model_idx % RING) * BURST);
            chk("cmd_addr", bus.cmd_addr, exp_addr);
            q_addr.push_back(bus.cmd_addr);
            model_idx++; model_out++; hs_cnt++;
            due = cyc + $urandom_range(b_dmax, b_dmin);
            if (due < last_due) due = last_due;
            last_due = due;
            q_b.push_back(due);
        end
        if (b_hs) begin
            void'(q_b.pop_front());
            model_out--; b_cnt++;
            if (bad) exp_err = 1'b1;
        end
        hold_pend = bus.cmd_valid && !rdy;
        hold_addr = bus.cmd_addr;
        @(posedge m_axi_aclk); #1;
        cyc++;
        chk("outstanding", 32'(o_outstanding), 32'(model_out));
        if (o_frame_done) fd_cnt++;
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_bresp  = 2'b00;
        i_start          = 1'b0;
    endtask

    task automatic start_frame(input int len, input bit rdy);
        hs_cnt = 0; fd_cnt = 0; b_cnt = 0;
        i_start = 1'b1;
        i_frame_len = 16'(len);
        cycle(rdy, 1'b1, 1'b0);
    endtask

    task automatic run_until_done(input int bound, input bit rnd);
        for (int i = 0; i < bound && fd_cnt == 0; i++)
            cycle(rnd ? ($urandom_range(3, 0) != 0) : 1'b1, 1'b1, 1'b0);
        chk("frame_done_seen", 32'(fd_cnt), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'h2000_0000, 1'b0, 1'b0, 4'd0, 1'b0};
        tbl[1]  = '{1'b1, 16'd2, 1'b0, 1'b0, 1'b1, 32'h2000_0000, 1'b1, 1'b0, 4'd0, 1'b0};
        tbl[2]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 32'h2000_0080, 1'b1, 1'b0, 4'd1, 1'b0};
        tbl[3]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 32'h2000_0100, 1'b1, 1'b0, 4'd2, 1'b0};
        tbl[4]  = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 32'h2000_0100, 1'b1, 1'b0, 4'd1, 1'b0};
        tbl[5]  = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 32'h2000_0100, 1'b1, 1'b0, 4'd0, 1'b0};
        tbl[6]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'h2000_0100, 1'b1, 1'b1, 4'd0, 1'b0};
        tbl[7]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'h2000_0100, 1'b0, 1'b0, 4'd0, 1'b0};
        tbl[8]  = '{1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 32'h2000_0100, 1'b0, 1'b0, 4'd0, 1'b0};
        tbl[9]  = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 32'h2000_0100, 1'b0, 1'b0, 4'd0, 1'b1};
        tbl[10] = '{1'b1, 16'd1, 1'b1, 1'b0, 1'b1, 32'h2000_0100, 1'b1, 1'b0, 4'd0, 1'b1};
        tbl[11] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 32'h2000_0180, 1'b1, 1'b0, 4'd1, 1'b1};
        tbl[12] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 32'h2000_0180, 1'b1, 1'b0, 4'd0, 1'b1};
        tbl[13] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'h2000_0180, 1'b1, 1'b1, 4'd0, 1'b1};
        tbl[14] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'h2000_0180, 1'b0, 1'b0, 4'd0, 1'b1};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            i_start = tbl[i].st;
            i_frame_len = tbl[i].len;
            bus.cmd_ready = tbl[i].rdy;
            bus.m_axi_bvalid = tbl[i].bv;
            bus.m_axi_bresp = 2'b00;
            @(posedge m_axi_aclk); #1;
            chk($sformatf("vec%0d_valid", i), 32'(bus.cmd_valid), 32'(tbl[i].e_v));
            chk($sformatf("vec%0d_addr", i), bus.cmd_addr, tbl[i].e_a);
            chk($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(tbl[i].e_bz));
            chk($sformatf("vec%0d_done", i), 32'(o_frame_done), 32'(tbl[i].e_fd));
            chk($sformatf("vec%0d_outst", i), 32'(o_outstanding), 32'(tbl[i].e_o));
            chk($sformatf("vec%0d_err", i), 32'(o_err), 32'(tbl[i].e_e));
            chk($sformatf("vec%0d_bready", i), 32'(bus.m_axi_bready), 32'd1);
        end

        // Four-burst frame, B two cycles after each command.
        do_reset();
        b_dmin = 2; b_dmax = 2;
        start_frame(4, 1'b1);
        run_until_done(60, 1'b0);
        chk("f4_cmds", 32'(hs_cnt), 32'd4);
        chk("f4_addr3", q_addr[3], 32'h2000_0180);
        cycle(1'b1, 1'b1, 1'b0);
        chk("f4_idle_busy", 32'(o_busy), 32'd0);
        chk("f4_done_count", 32'(fd_cnt), 32'd1);

        // Outstanding limit with B withheld, then one release.
        do_reset();
        b_dmin = 1; b_dmax = 1;
        start_frame(8, 1'b1);
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        chk("lim_cmds", 32'(hs_cnt), 32'd4);
        chk("lim_valid_low", 32'(bus.cmd_valid), 32'd0);
        chk("lim_outst", 32'(o_outstanding), 32'd4);
        cycle(1'b1, 1'b1, 1'b0);
        chk("lim_valid_again", 32'(bus.cmd_valid), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        chk("lim_fifth_cmd", 32'(hs_cnt), 32'd5);

        // Stall with cmd_ready low, then reset mid-frame.
        do_reset();
        start_frame(3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            chk("stall_valid", 32'(bus.cmd_valid), 32'd1);
            chk("stall_addr", bus.cmd_addr, BASE);
        end
        do_reset();

        // Abort together with the third handshake.
        b_dmin = 3; b_dmax = 3;
        start_frame(10, 1'b1);
        for (int i = 0; i < 10 && hs_cnt < 2; i++) cycle(1'b1, 1'b1, 1'b0);
        i_abort = 1'b1;
        cycle(1'b1, 1'b1, 1'b0);
        chk("abort_valid_low", 32'(bus.cmd_valid), 32'd0);
        run_until_done(40, 1'b0);
        chk("abort_cmds", 32'(hs_cnt), 32'd3);
        chk("abort_bs_before_done", 32'(b_cnt), 32'd3);
        i_abort = 1'b0;
        cycle(1'b1, 1'b1, 1'b0);

        // Pointer wrap across frames.
        do_reset();
        b_dmin = 1; b_dmax = 1;
        start_frame(7, 1'b1);
        run_until_done(60, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        start_frame(2, 1'b1);
        run_until_done(60, 1'b0);
        chk("wrap_addr_last", q_addr[7], 32'h2000_0380);
        chk("wrap_addr_first", q_addr[8], 32'h2000_0000);
        cycle(1'b1, 1'b1, 1'b0);

        // SLVERR on the second B response.
        do_reset();
        b_dmin = 1; b_dmax = 1;
        start_frame(4, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, (b_cnt == 1));
        chk("slverr_err", 32'(o_err), 32'(exp_err));
        chk("slverr_err_set", 32'(o_err), 32'd1);
        chk("slverr_outst", 32'(o_outstanding), 32'd0);
`ifdef WR_SCHED_ERR_STOP_EN
        chk("halt_no_done", 32'(fd_cnt), 32'd0);
        chk("halt_busy", 32'(o_busy), 32'd1);
        chk("halt_valid", 32'(bus.cmd_valid), 32'd0);
`else
        chk("slverr_done", 32'(fd_cnt), 32'd1);
        chk("slverr_cmds", 32'(hs_cnt), 32'd4);
        chk("slverr_idle", 32'(o_busy), 32'd0);
`endif

        // Randomized frames against the reference model.
        do_reset();
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(12, 1);
            b_dmin = 1;
            b_dmax = $urandom_range(6, 1);
            repeat ($urandom_range(2, 0)) cycle(1'b1, 1'b1, 1'b0);
            start_frame(len, ($urandom_range(1, 0) != 0));
            run_until_done(400, 1'b1);
            chk("rand_cmds", 32'(hs_cnt), 32'(len));
            cycle(1'b1, 1'b1, 1'b0);
            chk("rand_idle", 32'(o_busy), 32'd0);
        end
        chk("rand_err", 32'(o_err), 32'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
